// File: rtl/pll_startup_seq_pkg.sv
// Shared state encoding for the PLL startup sequencer.
// Plain localparams keep the encoding usable by older tools that lack enum support.
package pll_startup_seq_pkg;

    localparam logic [1:0] S_WAIT_LOCK = 2'd0;
    localparam logic [1:0] S_SETTLE    = 2'd1;
    localparam logic [1:0] S_RUN       = 2'd2;
    localparam logic [1:0] S_LOST      = 2'd3;

endpackage

// File: rtl/pll_startup_seq_sync2.sv
// Generic two-flop synchroniser for a single asynchronous level input.
// Both flops clear to 0, so the synchronised level reads as low out of reset.
module sync2 (
    input  logic clock,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_startup_seq.sv
// Startup sequencer behind the PLL: waits for a stable lock, releases the TDC reset,
// debounces lock loss in RUN and keeps a saturating count of genuine losses.
module pll_startup_seq
    import pll_startup_seq_pkg::*;
#(
    parameter int USE_LOCK        = 1,
    parameter int SETTLE_CYCLES   = 4096,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int LOSS_W          = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              lock_async,
    input  logic              loss_clear,
    output logic              tdc_reset,
    output logic              ready,
    output logic [LOSS_W-1:0] loss_count
);

    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int LOW_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [LOW_W-1:0]    LOW_LAST    = LOW_W'(DEBOUNCE_CYCLES - 1);

    logic                w_lockS;
    logic [1:0]          w_nextState;
    logic [1:0]          r_state;
    logic [SETTLE_W-1:0] r_settleCnt;
    logic [LOW_W-1:0]    r_lowCnt;
    logic                r_tdcReset;
    logic                r_ready;
    logic [LOSS_W-1:0]   r_lossCount;

    // Boards without a LOCK pin behave as permanently locked.
    generate
        if (USE_LOCK != 0) begin : g_lockSync
            sync2 u_lockSync (
                .clock (clock),
                .reset (reset),
                .i_d   (lock_async),
                .o_q   (w_lockS)
            );
        end else begin : g_lockTied
            logic w_unusedLock;
            assign w_unusedLock = lock_async;
            assign w_lockS      = 1'b1;
        end
    endgenerate

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_WAIT_LOCK: if (w_lockS) w_nextState = S_SETTLE;
            S_SETTLE: begin
                if (!w_lockS)
                    w_nextState = S_WAIT_LOCK;
                else if (r_settleCnt == SETTLE_LAST)
                    w_nextState = S_RUN;
            end
            S_RUN:       if (!w_lockS && (r_lowCnt == LOW_LAST)) w_nextState = S_LOST;
            S_LOST:      w_nextState = S_WAIT_LOCK;
            default:     w_nextState = S_WAIT_LOCK;
        endcase
    end

    // Outputs are decoded from the next state so they change on the RUN entry/exit edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_WAIT_LOCK;
            r_settleCnt <= '0;
            r_lowCnt    <= '0;
            r_tdcReset  <= 1'b1;
            r_ready     <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_settleCnt <= ((r_state == S_SETTLE) && (w_nextState == S_SETTLE))
                           ? r_settleCnt + 1'b1 : '0;
            r_lowCnt    <= ((r_state == S_RUN) && (w_nextState == S_RUN) && !w_lockS)
                           ? r_lowCnt + 1'b1 : '0;
            r_tdcReset  <= (w_nextState != S_RUN);
            r_ready     <= (w_nextState == S_RUN);
        end
    end

    // The count steps on the edge into LOST so it is already visible during LOST.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_lossCount <= '0;
        else if (loss_clear)
            r_lossCount <= '0;
        else if ((w_nextState == S_LOST) && (r_lossCount != {LOSS_W{1'b1}}))
            r_lossCount <= r_lossCount + 1'b1;
    end

    assign tdc_reset  = r_tdcReset;
    assign ready      = r_ready;
    assign loss_count = r_lossCount;

endmodule
